// File: rtl/scl_seq_pkg.sv
// Shared types and default sizing for the SCL frame sequencer.
package scl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_OD,
    ST_PP,
    ST_STOP
  } seq_state_e;

  localparam int DEF_CNT_W       = 6;
  localparam int DEF_CAS_CYCLES  = 2;
  localparam int DEF_STOP_CYCLES = 4;

endpackage

// File: rtl/scl_seq_delay.sv
// Loadable down-counter with a zero flag; one instance times both START and STOP.
module scl_seq_delay
  import scl_seq_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/scl_frame_sequencer.sv
// Sequences the SCL generator through START, OD cycles, PP cycles and STOP.
// Optional abort input and behaviour enabled by defining SCL_SEQ_ABORT_EN.
module scl_frame_sequencer
  import scl_seq_pkg::*;
#(
  parameter int CAS_CYCLES  = DEF_CAS_CYCLES,
  parameter int STOP_CYCLES = DEF_STOP_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             i_sdr_ctrl_clk,
  input  logic             i_sdr_ctrl_rst,
  input  logic             i_seq_req,
  input  logic [CNT_W-1:0] i_seq_od_bits,
  input  logic [CNT_W-1:0] i_seq_pp_bits,
  input  logic             i_seq_hold,
  input  logic             i_scl_pos_edge,
  input  logic             i_scl_neg_edge,
`ifdef SCL_SEQ_ABORT_EN
  input  logic             i_seq_abort,
`endif
  output logic             o_seq_ack,
  output logic             o_seq_busy,
  output logic             o_seq_done,
  output logic [CNT_W-1:0] o_seq_bit_cnt,
  output logic             o_scl_gen_pp_od,
  output logic             o_scl_gen_stall,
  output logic             o_sdr_ctrl_scl_idle,
  output logic             o_timer_cas
);

  localparam int DLY_MAX = (CAS_CYCLES > STOP_CYCLES) ? CAS_CYCLES : STOP_CYCLES;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam logic [DLY_W-1:0] CAS_VAL  = DLY_W'(CAS_CYCLES);
  localparam logic [DLY_W-1:0] STOP_VAL = DLY_W'(STOP_CYCLES);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] od_q, od_d, pp_q, pp_d, bit_cnt_q, bit_cnt_d, phase_bits;
  logic ack_q, ack_d, busy_q, busy_d, done_q, done_d, cas_q, cas_d;
  logic pp_od_q, pp_od_d, stall_q, stall_d, idle_q, idle_d;
  logic dly_load, dly_zero, goto_stop;
  logic [DLY_W-1:0] dly_val;

`ifdef SCL_SEQ_ABORT_EN
  logic abort_q, abort_d, armed_q, armed_d;
`else
  logic unused_neg_edge;
  assign unused_neg_edge = i_scl_neg_edge;
`endif

  scl_seq_delay #(.W(DLY_W)) u_delay (
    .clk      (i_sdr_ctrl_clk),
    .rst      (i_sdr_ctrl_rst),
    .load     (dly_load),
    .load_val (dly_val),
    .zero     (dly_zero)
  );

  always_comb begin
    state_d    = state_q;
    od_d       = od_q;
    pp_d       = pp_q;
    bit_cnt_d  = bit_cnt_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    cas_d      = 1'b0;
    busy_d     = busy_q;
    pp_od_d    = pp_od_q;
    idle_d     = idle_q;
    dly_load   = 1'b0;
    dly_val    = CAS_VAL;
    goto_stop  = 1'b0;
    phase_bits = '0;
`ifdef SCL_SEQ_ABORT_EN
    abort_d = abort_q;
    armed_d = armed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_seq_req && (i_seq_od_bits != '0 || i_seq_pp_bits != '0)) begin
          od_d     = i_seq_od_bits;
          pp_d     = i_seq_pp_bits;
          ack_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_START;
          dly_load = 1'b1;
        end
      end
      ST_START: begin
`ifdef SCL_SEQ_ABORT_EN
        // Aborting before any SCL activity needs no neg edge: first pos edge ends it.
        if (i_seq_abort) begin
          abort_d = 1'b1;
          armed_d = 1'b1;
        end
`endif
        if (dly_zero) begin
          cas_d  = 1'b1;
          idle_d = 1'b0;
          if (od_q != '0) state_d = ST_OD;
          else begin
            state_d = ST_PP;
            pp_od_d = 1'b1;
          end
        end
      end
      ST_OD, ST_PP: begin
        phase_bits = (state_q == ST_OD) ? od_q : pp_q;
        if (i_scl_pos_edge) begin
          if (bit_cnt_q == phase_bits - CNT_W'(1)) begin
            bit_cnt_d = '0;
            if (state_q == ST_OD && pp_q != '0) begin
              state_d = ST_PP;
              pp_od_d = 1'b1;
            end else goto_stop = 1'b1;
          end else bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
`ifdef SCL_SEQ_ABORT_EN
        if (i_seq_abort) abort_d = 1'b1;
        if (abort_q && i_scl_neg_edge) armed_d = 1'b1;
        if (armed_q && i_scl_pos_edge) begin
          bit_cnt_d = '0;
          pp_od_d   = pp_od_q;
          goto_stop = 1'b1;
        end
`endif
        if (goto_stop) begin
          state_d  = ST_STOP;
          idle_d   = 1'b1;
          dly_load = 1'b1;
          dly_val  = STOP_VAL;
        end
      end
      ST_STOP: begin
        if (dly_zero) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pp_od_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef SCL_SEQ_ABORT_EN
    if (state_q == ST_IDLE || state_q == ST_STOP) begin
      abort_d = 1'b0;
      armed_d = 1'b0;
    end
`endif
    // Keyed on the next state so stall never leaks into STOP.
    stall_d = i_seq_hold && (state_d == ST_OD || state_d == ST_PP);
  end

  always_ff @(posedge i_sdr_ctrl_clk or posedge i_sdr_ctrl_rst) begin
    if (i_sdr_ctrl_rst) begin
      state_q   <= ST_IDLE;
      od_q      <= '0;
      pp_q      <= '0;
      bit_cnt_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cas_q     <= 1'b0;
      pp_od_q   <= 1'b0;
      stall_q   <= 1'b0;
      idle_q    <= 1'b1;
`ifdef SCL_SEQ_ABORT_EN
      abort_q   <= 1'b0;
      armed_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      od_q      <= od_d;
      pp_q      <= pp_d;
      bit_cnt_q <= bit_cnt_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cas_q     <= cas_d;
      pp_od_q   <= pp_od_d;
      stall_q   <= stall_d;
      idle_q    <= idle_d;
`ifdef SCL_SEQ_ABORT_EN
      abort_q   <= abort_d;
      armed_q   <= armed_d;
`endif
    end
  end

  assign o_seq_ack           = ack_q;
  assign o_seq_busy          = busy_q;
  assign o_seq_done          = done_q;
  assign o_seq_bit_cnt       = bit_cnt_q;
  assign o_scl_gen_pp_od     = pp_od_q;
  assign o_scl_gen_stall     = stall_q;
  assign o_sdr_ctrl_scl_idle = idle_q;
  assign o_timer_cas         = cas_q;

endmodule

// File: tb/tb_scl_frame_sequencer.sv
// Randomized frame bench for scl_frame_sequencer against a cycle-arithmetic frame model.
module tb_scl_frame_sequencer;

  localparam int CAS  = 2;
  localparam int STOP = 4;
  localparam int W    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, hold = 1'b0, pos = 1'b0, neg = 1'b0, abort = 1'b0;
  logic [W-1:0] od_in = '0, pp_in = '0;
  logic ack, busy, done, ppod, stall, idle, tcas;
  logic [W-1:0] bcnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  scl_frame_sequencer #(.CAS_CYCLES(CAS), .STOP_CYCLES(STOP), .CNT_W(W)) dut (
    .i_sdr_ctrl_clk      (clk),
    .i_sdr_ctrl_rst      (rst),
    .i_seq_req           (req),
    .i_seq_od_bits       (od_in),
    .i_seq_pp_bits       (pp_in),
    .i_seq_hold          (hold),
    .i_scl_pos_edge      (pos),
    .i_scl_neg_edge      (neg),
`ifdef SCL_SEQ_ABORT_EN
    .i_seq_abort         (abort),
`endif
    .o_seq_ack           (ack),
    .o_seq_busy          (busy),
    .o_seq_done          (done),
    .o_seq_bit_cnt       (bcnt),
    .o_scl_gen_pp_od     (ppod),
    .o_scl_gen_stall     (stall),
    .o_sdr_ctrl_scl_idle (idle),
    .o_timer_cas         (tcas)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completed cycles in the current phase after n SCL rising edges of the frame.
  function automatic int exp_cnt(int n, int od, int pp);
    if (n < od) return n;
    if (n - od < pp) return n - od;
    return 0;
  endfunction

  function automatic logic exp_ppod(int n, int od, int pp);
    return (n >= od) && (pp != 0);
  endfunction

  // One complete frame; skip_req means the ack cycle is already current.
  task automatic run_frame(input int od, input int pp, input int hold_at, input int gap_max,
                           input bit keep_req, input bit skip_req);
    int t, n, gap;
    logic [W-1:0] frz;
    if (!skip_req) begin
      req = 1'b1; od_in = W'(od); pp_in = W'(pp);
      step();
    end
    if (!keep_req) begin
      req = 1'b0; od_in = W'($urandom); pp_in = W'($urandom);
    end
    checks++; if (ack !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL accept got ack=%b busy=%b exp 1/1", ack, busy); end
    t = 0;
    while (tcas !== 1'b1 && t < 40) begin
      step(); t++;
      checks++; if (ack !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL start_flags got ack=%b busy=%b exp 0/1", ack, busy); end
    end
    checks++; if (t != CAS + 1) begin failures++; $display("FAIL cas_latency got=%0d exp=%0d", t, CAS + 1); end
    n = 0;
    while (n < od + pp) begin
      gap = $urandom_range(1, gap_max);
      for (int g = 0; g < gap; g++) begin
        step();
        checks++;
        if (idle !== 1'b0 || tcas !== 1'b0 || ack !== 1'b0 || stall !== 1'b0 ||
            bcnt !== W'(exp_cnt(n, od, pp)) || ppod !== exp_ppod(n, od, pp)) begin
          failures++;
          $display("FAIL phase n=%0d got idle=%b cas=%b ack=%b stall=%b cnt=%0d ppod=%b exp 0/0/0/0 cnt=%0d ppod=%b",
                   n, idle, tcas, ack, stall, bcnt, ppod, exp_cnt(n, od, pp), exp_ppod(n, od, pp));
        end
      end
      pos = 1'b1;
      if (n == hold_at) hold = 1'b1;
      step();
      pos = 1'b0; n++;
      if (n < od + pp) begin
        checks++;
        if (bcnt !== W'(exp_cnt(n, od, pp)) || ppod !== exp_ppod(n, od, pp)) begin
          failures++;
          $display("FAIL edge n=%0d got cnt=%0d ppod=%b exp cnt=%0d ppod=%b", n, bcnt, ppod, exp_cnt(n, od, pp), exp_ppod(n, od, pp));
        end
      end
      if (hold) begin
        frz = W'(exp_cnt(n, od, pp));
        for (int h = 0; h < 40; h++) begin
          if (h > 0) step();
          checks++;
          if (stall !== 1'b1 || bcnt !== frz) begin failures++; $display("FAIL hold h=%0d got stall=%b cnt=%0d exp 1 cnt=%0d", h, stall, bcnt, frz); end
        end
        hold = 1'b0;
        step();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hold_release got stall=%b exp 0", stall); end
      end
    end
    checks++;
    if (idle !== 1'b1 || bcnt !== '0 || ppod !== (pp != 0) || busy !== 1'b1) begin
      failures++;
      $display("FAIL stop_entry got idle=%b cnt=%0d ppod=%b busy=%b exp 1 0 %b 1", idle, bcnt, ppod, busy, pp != 0);
    end
    t = 0;
    while (done !== 1'b1 && t < 40) begin
      step(); t++;
    end
    checks++; if (t != STOP + 1) begin failures++; $display("FAIL done_latency got=%0d exp=%0d", t, STOP + 1); end
    checks++; if (busy !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL done_flags got busy=%b idle=%b exp 0/1", busy, idle); end
    step();
    checks++;
    if (done !== 1'b0 || ack !== keep_req || busy !== keep_req) begin
      failures++;
      $display("FAIL post_done got done=%b ack=%b busy=%b exp 0 %b %b", done, ack, busy, keep_req, keep_req);
    end
    if (keep_req) req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if (idle !== 1'b1 || busy !== 1'b0 || ack !== 1'b0 || done !== 1'b0 || bcnt !== '0 ||
        ppod !== 1'b0 || stall !== 1'b0 || tcas !== 1'b0) begin
      failures++;
      $display("FAIL reset got idle=%b busy=%b ack=%b done=%b cnt=%0d ppod=%b stall=%b cas=%b",
               idle, busy, ack, done, bcnt, ppod, stall, tcas);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_od_only();
    run_frame(9, 0, -1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_od_pp();
    run_frame(9, 18, -1, 4, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    run_frame(9, 18, 14, 3, 1'b0, 1'b0);
  endtask

  task automatic test_zero_request();
    req = 1'b1; od_in = '0; pp_in = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL zero_req got ack=%b busy=%b idle=%b exp 0 0 1", ack, busy, idle); end
    end
    req = 1'b0;
    step();
    run_frame(0, 4, -1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int t;
    req = 1'b1; od_in = 6'd9; pp_in = 6'd5;
    step();
    req = 1'b0;
    t = 0;
    while (tcas !== 1'b1 && t < 40) begin step(); t++; end
    for (int i = 0; i < 3; i++) begin
      step(); pos = 1'b1; step(); pos = 1'b0;
    end
    checks++; if (bcnt !== 6'd3) begin failures++; $display("FAIL mid_od_cnt got=%0d exp=3", bcnt); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (idle !== 1'b1 || busy !== 1'b0 || bcnt !== '0 || ppod !== 1'b0 || stall !== 1'b0 || tcas !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got idle=%b busy=%b cnt=%0d ppod=%b stall=%b cas=%b", idle, busy, bcnt, ppod, stall, tcas);
    end
    step(); step();
    rst = 1'b0;
    step();
    run_frame(9, 18, -1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(5, 3, -1, 2, 1'b1, 1'b0);
    run_frame(5, 3, -1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int od, pp, ha;
    for (int k = 0; k < 5; k++) begin
      od = $urandom_range(0, 12);
      pp = $urandom_range(0, 12);
      if (od + pp == 0) pp = 1;
      ha = (od + pp >= 2 && ($urandom_range(0, 1) == 1)) ? $urandom_range(0, od + pp - 2) : -1;
      run_frame(od, pp, ha, 4, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

`ifdef SCL_SEQ_ABORT_EN
  task automatic test_abort();
    int t;
    req = 1'b1; od_in = 6'd9; pp_in = 6'd5;
    step();
    req = 1'b0;
    t = 0;
    while (tcas !== 1'b1 && t < 40) begin step(); t++; end
    for (int i = 0; i < 3; i++) begin
      step(); pos = 1'b1; step(); pos = 1'b0;
    end
    abort = 1'b1; step(); abort = 1'b0;
    step(); neg = 1'b1; step(); neg = 1'b0; step();
    checks++; if (idle !== 1'b0 || bcnt !== 6'd3) begin failures++; $display("FAIL abort_wait got idle=%b cnt=%0d exp 0 3", idle, bcnt); end
    pos = 1'b1; step(); pos = 1'b0;
    checks++; if (idle !== 1'b1 || ppod !== 1'b0 || bcnt !== '0) begin failures++; $display("FAIL abort_stop got idle=%b ppod=%b cnt=%0d exp 1 0 0", idle, ppod, bcnt); end
    t = 0;
    while (done !== 1'b1 && t < 40) begin
      step(); t++;
      checks++; if (ppod !== 1'b0) begin failures++; $display("FAIL abort_ppod got=%b exp=0", ppod); end
    end
    checks++; if (t != STOP + 1) begin failures++; $display("FAIL abort_done got=%0d exp=%0d", t, STOP + 1); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_od_only();
    test_od_pp();
    test_hold();
    test_zero_request();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
`ifdef SCL_SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
